// File: rtl/keccak_squeezer.sv
// keccak_squeezer: streams SHA3/SHAKE128 digest words out of the Keccak rate lanes,
// requesting further permutations when a SHAKE output outruns one rate block.
module keccak_squeezer #(
  parameter int WORD_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [7:0]        out_len,
  input  logic [1599:0]     state_in,
  input  logic              state_valid,
  output logic              perm_req,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, WAIT_STATE, EMIT} state_t;
  state_t st, st_n;
  logic [1599:0] cap, cap_n;
  logic [7:0] rem, rem_n, total;
  logic [4:0] idx, idx_n, rc, rc_n, rate;
  logic [1:0] md, md_n;
  logic [10:0] sel;
  logic [WORD_W-1:0] dout_n;
  logic dv_n, dl_n, pr_n, done_n, busy_n;
  assign rate  = md == 2'd0 ? 5'd9 : md == 2'd1 ? 5'd13 : md == 2'd2 ? 5'd17 : 5'd21;
  assign total = mode == 2'd0 ? 8'd8 : mode == 2'd1 ? 8'd6 : mode == 2'd2 ? 8'd4 :
                 out_len == 8'd0 ? 8'd1 : out_len;
  assign sel   = {idx + 5'd1, 6'd0};
  always_comb begin
    st_n   = st;
    cap_n  = cap;
    rem_n  = rem;
    idx_n  = idx;
    rc_n   = rc;
    md_n   = md;
    dout_n = dout;
    dv_n   = dout_valid;
    dl_n   = dout_last;
    pr_n   = 1'b0;
    done_n = 1'b0;
    // a start landing on the done cycle belongs to the finished squeeze and is dropped
    if (st == IDLE && start && !done) begin
      md_n  = mode;
      rem_n = total;
      st_n  = WAIT_STATE;
    end else if (st == WAIT_STATE && state_valid) begin
      cap_n  = state_in;
      idx_n  = 5'd0;
      rc_n   = rate;
      dout_n = state_in[WORD_W-1:0];
      dv_n   = 1'b1;
      dl_n   = rem == 8'd1;
      st_n   = EMIT;
    end else if (st == EMIT && dout_ready) begin
      rem_n = rem - 8'd1;
      idx_n = idx + 5'd1;
      rc_n  = rc - 5'd1;
      if (rem == 8'd1) begin
        dv_n   = 1'b0;
        dl_n   = 1'b0;
        done_n = 1'b1;
        st_n   = IDLE;
      end else if (rc == 5'd1) begin
        dv_n = 1'b0;
        pr_n = 1'b1;
        st_n = WAIT_STATE;
      end else begin
        dout_n = cap[sel +: WORD_W];
        dl_n   = rem == 8'd2;
      end
    end
    busy_n = st_n != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      cap        <= '0;
      rem        <= '0;
      idx        <= '0;
      rc         <= '0;
      md         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      perm_req   <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      st         <= st_n;
      cap        <= cap_n;
      rem        <= rem_n;
      idx        <= idx_n;
      rc         <= rc_n;
      md         <= md_n;
      dout       <= dout_n;
      dout_valid <= dv_n;
      dout_last  <= dl_n;
      perm_req   <= pr_n;
      done       <= done_n;
      busy       <= busy_n;
    end
  end
endmodule

// File: doc/keccak_squeezer.md
KECCAK_SQUEEZER -- requirements
Module: keccak_squeezer

Interface
REQ-001 Parameter: WORD_W, 64, output word width; 64 is the only supported value.
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  one-cycle request to begin a squeeze; acted on only in IDLE.
REQ-005 Port: mode  input  2  hash mode, sampled on start: 0 SHA3-512, 1 SHA3-384, 2 SHA3-256, 3 SHAKE128.
REQ-006 Port: out_len  input  8  SHAKE128 output length in 64-bit words, sampled on start; 0 is treated as 1.
REQ-007 Port: state_in  input  1600  Keccak state; lane i = state_in[64*i+63 : 64*i].
REQ-008 Port: state_valid  input  1  one-cycle pulse: permutation complete, state_in valid this cycle.
REQ-009 Port: perm_req  output  1  one-cycle pulse requesting another permutation (SHAKE only).
REQ-010 Port: dout  output  64  digest word.
REQ-011 Port: dout_valid  output  1  dout holds a valid word.
REQ-012 Port: dout_ready  input  1  downstream accepts dout.
REQ-013 Port: dout_last  output  1  high with dout_valid on the final digest word.
REQ-014 Port: busy  output  1  high in every state except IDLE.
REQ-015 Port: done  output  1  one-cycle pulse after the final word is accepted.

Function
REQ-016 States: IDLE, WAIT_STATE, EMIT; all outputs and state are registered.
REQ-017 Rate words per mode: 0→9, 1→13, 2→17, 3→21. Total words: 0→8, 1→6, 2→4, 3→out_len.
REQ-018 IDLE + start: latch mode; load remaining = total words; go to WAIT_STATE. start is ignored outside IDLE.
REQ-019 WAIT_STATE + state_valid: capture the rate lanes of state_in (lanes 0..rate-1); set idx=0; load rate_cnt = rate words; go to EMIT.
REQ-020 Latency: a state_valid pulse in cycle n gives dout_valid=1 in cycle n+1 with dout = lane 0.
REQ-021 EMIT: dout_valid=1 and dout = captured lane[idx], in lane order 0,1,2,...
REQ-022 Handshake: a transfer occurs on a cycle with dout_valid & dout_ready; remaining decrements, idx increments, and rate_cnt decrements.
REQ-023 While dout_valid & ~dout_ready, dout and dout_last hold unchanged and no counter moves.
REQ-024 dout_last = dout_valid & (remaining == 1).
REQ-025 A transfer with remaining==1 pulses done the next cycle, drops dout_valid, and returns to IDLE.
REQ-026 A transfer with remaining>1 and rate_cnt==1 (rate exhausted) pulses perm_req the next cycle, drops dout_valid, and returns to WAIT_STATE; the next state_valid restarts idx at 0.
REQ-027 Modes 0-2 never assert perm_req, because total words < rate words.
REQ-028 state_valid is ignored in IDLE and EMIT; the captured state is not overwritten.
REQ-029 start coinciding with done (back-to-back) is ignored; start is accepted from the first IDLE cycle onward.
REQ-030 Counters are 8 bits (remaining) and 5 bits (idx, rate_cnt); none wraps, because transitions occur before 0 is decremented.

Reset
REQ-031 rst asserted forces IDLE; dout=0, dout_valid=0, dout_last=0, perm_req=0, done=0, busy=0; all counters and the captured state are 0.
REQ-032 rst mid-squeeze (in WAIT_STATE or EMIT) aborts the operation with no done pulse; after rst deasserts, the block waits in IDLE for a new start.

Verification
REQ-033 Mode 0, dout_ready=1, lane i = i+1: start, then state_valid → dout 1..8 on 8 consecutive cycles, dout_last on 8, done one cycle later, perm_req never.
REQ-034 Mode 2 with dout_ready toggling 1,0,1,0: → 4 words 1..4, each held stable during stalls; dout_last on word 4; done pulses once.
REQ-035 Mode 3, out_len=25: → 21 words (lanes 0..20), then a perm_req pulse; a second state_valid → 4 more words from lanes 0..3, dout_last on the 25th word, then done.
REQ-036 Mode 3, out_len=0: → exactly 1 word with dout_last=1, then done.
REQ-037 Mode 1, rst asserted after 3 transfers: → all outputs 0 immediately and no done; a new start plus state_valid emits a full 6 words.
REQ-038 Spurious state_valid in IDLE or EMIT, and start while busy: → no change to the output sequence or to the counters.
